// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------
// alu_seq_pkg : function codes, FSM states, latencies for alu_seq_w
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  localparam logic [4:0] FS_PASS_S = 5'h00;
  localparam logic [4:0] FS_PASS_T = 5'h01;
  localparam logic [4:0] FS_ADD    = 5'h02;
  localparam logic [4:0] FS_ADDU   = 5'h03;
  localparam logic [4:0] FS_SUB    = 5'h04;
  localparam logic [4:0] FS_SUBU   = 5'h05;
  localparam logic [4:0] FS_SLT    = 5'h06;
  localparam logic [4:0] FS_SLTU   = 5'h07;
  localparam logic [4:0] FS_AND    = 5'h08;
  localparam logic [4:0] FS_OR     = 5'h09;
  localparam logic [4:0] FS_XOR    = 5'h0A;
  localparam logic [4:0] FS_NOR    = 5'h0B;
  localparam logic [4:0] FS_SRL    = 5'h0C;
  localparam logic [4:0] FS_SRA    = 5'h0D;
  localparam logic [4:0] FS_SLL    = 5'h0E;
  localparam logic [4:0] FS_MULU   = 5'h1C;
  localparam logic [4:0] FS_DIVU   = 5'h1D;
  localparam logic [4:0] FS_MUL    = 5'h1E;
  localparam logic [4:0] FS_DIV    = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int LAT_SINGLE = 1;

  function automatic int lat_mul(input int w);
    return w + 1;
  endfunction

  function automatic int lat_div(input int w);
    return w + 2;
  endfunction

  // 1C..1F: bit0 selects divide, bit1 selects signed
  function automatic logic is_muldiv(input logic [4:0] fs);
    return fs[4:2] == 3'b111;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iter_muldiv_w.sv
// ---------------------------------------------------------------
// iter_muldiv_w : bit-serial shift-add multiply / restoring divide
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module iter_muldiv_w #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         div,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         fin
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           fix_q, fix_d;
  logic           div_q, div_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           dz_q, dz_d;

  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W-1:0]   mul_add;
  logic [W:0]     mul_sum;
  logic [W:0]     rem_sh;
  logic [W:0]     rem_new;
  logic           ge;
  logic [W-1:0]   q_raw, r_raw;
  logic [2*W-1:0] acc_out;

  always_comb begin
    a_neg   = sgn && a[W-1];
    b_neg   = sgn && b[W-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    mul_add = acc_q[0] ? m_q : {W{1'b0}};
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_add};
    rem_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
    ge      = rem_sh >= {1'b0, m_q};
    rem_new = ge ? (rem_sh - {1'b0, m_q}) : rem_sh;
    q_raw   = acc_q[W-1:0];
    r_raw   = acc_q[2*W-1:W];

    acc_d  = acc_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    fix_d  = fix_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;

    if (load) begin
      acc_d  = {{W{1'b0}}, a_mag};
      m_d    = b_mag;
      cnt_d  = '0;
      run_d  = 1'b1;
      fix_d  = 1'b0;
      div_d  = div;
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
      dz_d   = (b == '0);
    end else if (run_q) begin
      if (div_q) begin
        acc_d = {rem_new[W-1:0], acc_q[W-2:0], ge};
      end else begin
        acc_d = {mul_sum, acc_q[W-1:1]};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W-1)) begin
        run_d = 1'b0;
        fix_d = div_q;
      end
    end else if (fix_q) begin
      // A zero divisor leaves |s| as remainder, so the remainder sign fix restores s itself
      fix_d = 1'b0;
      acc_d = {rneg_q ? -r_raw : r_raw,
               dz_q ? {W{1'b1}} : (qneg_q ? -q_raw : q_raw)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      fix_q  <= 1'b0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      fix_q  <= fix_d;
      div_q  <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

  // Products are sign-corrected on the way out; quotients were already fixed in place
  assign acc_out = (!div_q && qneg_q) ? -acc_q : acc_q;
  assign hi      = acc_out[2*W-1:W];
  assign lo      = acc_out[W-1:0];
  assign fin     = run_q && (cnt_q == CW'(W-1));

endmodule

`default_nettype wire

// File: rtl/alu_seq_w.sv
// ---------------------------------------------------------------
// alu_seq_w : multi-cycle ALU top (single-cycle unit, FSM, flags)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module alu_seq_w
  import alu_seq_pkg::*;
#(
  parameter int W   = 32,
  parameter int SHW = $clog2(W)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [4:0]     fs,
  input  logic [SHW-1:0] shamt,
  input  logic [W-1:0]   s,
  input  logic [W-1:0]   t,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   y_hi,
  output logic [W-1:0]   y_lo,
  output logic           c,
  output logic           v,
  output logic           n,
  output logic           z,
  output logic           dz
);

  state_e         state_q, state_d;
  logic [4:0]     fs_q, fs_d;
  logic [SHW-1:0] shamt_q, shamt_d;
  logic [W-1:0]   s_q, s_d;
  logic [W-1:0]   t_q, t_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   y_hi_q, y_hi_d;
  logic [W-1:0]   y_lo_q, y_lo_d;
  logic           c_q, c_d;
  logic           v_q, v_d;
  logic           n_q, n_d;
  logic           z_q, z_d;
  logic           dz_q, dz_d;

  logic           accept;
  logic           md_load;
  logic [W-1:0]   md_hi, md_lo;
  logic           md_fin;

  logic [W:0]     add_w, sub_w;
  logic [SHW-1:0] shm1;
  logic [W-1:0]   srl_src, sll_src;
  logic           sh_zero;
  logic [W-1:0]   sc_y;
  logic           sc_c, sc_v;

  assign accept  = start && !busy_q;
  assign md_load = accept && is_muldiv(fs);

  iter_muldiv_w #(.W(W)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (md_load),
    .div     (fs[0]),
    .sgn     (fs[1]),
    .a       (s),
    .b       (t),
    .hi      (md_hi),
    .lo      (md_lo),
    .fin     (md_fin)
  );

  // Single-cycle unit works on the operands latched at accept
  always_comb begin
    add_w   = {1'b0, s_q} + {1'b0, t_q};
    sub_w   = {1'b0, s_q} + {1'b0, ~t_q} + (W+1)'(1);
    shm1    = shamt_q - SHW'(1);
    srl_src = t_q >> shm1;
    sll_src = t_q << shm1;
    sh_zero = (shamt_q == '0);
    sc_y    = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    case (fs_q)
      FS_PASS_S: sc_y = s_q;
      FS_PASS_T: sc_y = t_q;
      FS_ADD: begin
        sc_y = add_w[W-1:0];
        sc_c = add_w[W];
        sc_v = (s_q[W-1] == t_q[W-1]) && (add_w[W-1] != s_q[W-1]);
      end
      FS_ADDU: begin
        sc_y = add_w[W-1:0];
        sc_c = add_w[W];
      end
      FS_SUB: begin
        sc_y = sub_w[W-1:0];
        sc_c = sub_w[W];
        sc_v = (s_q[W-1] != t_q[W-1]) && (sub_w[W-1] != s_q[W-1]);
      end
      FS_SUBU: begin
        sc_y = sub_w[W-1:0];
        sc_c = sub_w[W];
      end
      FS_SLT:  sc_y = {{(W-1){1'b0}}, $signed(s_q) < $signed(t_q)};
      FS_SLTU: sc_y = {{(W-1){1'b0}}, s_q < t_q};
      FS_AND:  sc_y = s_q & t_q;
      FS_OR:   sc_y = s_q | t_q;
      FS_XOR:  sc_y = s_q ^ t_q;
      FS_NOR:  sc_y = ~(s_q | t_q);
      FS_SRL: begin
        sc_y = t_q >> shamt_q;
        sc_c = !sh_zero && srl_src[0];
      end
      FS_SRA: begin
        sc_y = $unsigned($signed(t_q) >>> shamt_q);
        sc_c = !sh_zero && srl_src[0];
      end
      FS_SLL: begin
        sc_y = t_q << shamt_q;
        sc_c = !sh_zero && sll_src[W-1];
      end
      default: sc_y = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fs_d    = fs_q;
    shamt_d = shamt_q;
    s_d     = s_q;
    t_d     = t_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_hi_d  = y_hi_q;
    y_lo_d  = y_lo_q;
    c_d     = c_q;
    v_d     = v_q;
    n_d     = n_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (done_q) begin
          busy_d = 1'b0;
        end
        if (accept) begin
          fs_d    = fs;
          shamt_d = shamt;
          s_d     = s;
          t_d     = t;
          busy_d  = 1'b1;
          if (is_muldiv(fs)) begin
            state_d = fs[0] ? S_DIV : S_MUL;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_MUL: if (md_fin) state_d = S_DONE;
      S_DIV: if (md_fin) state_d = S_FIX;
      S_FIX: state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (is_muldiv(fs_q)) begin
          y_hi_d = md_hi;
          y_lo_d = md_lo;
          c_d    = 1'b0;
          v_d    = (fs_q == FS_DIV) && (s_q == {1'b1, {(W-1){1'b0}}})
                   && (t_q == {W{1'b1}});
          n_d    = fs_q[0] ? md_lo[W-1] : md_hi[W-1];
          dz_d   = fs_q[0] && (t_q == '0);
        end else begin
          y_hi_d = '0;
          y_lo_d = sc_y;
          c_d    = sc_c;
          v_d    = sc_v;
          n_d    = sc_y[W-1];
          dz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered alongside y so z is cleared by reset like the other flags
    z_d = (y_hi_d == '0) && (y_lo_d == '0);
    if (state_q != S_DONE) begin
      z_d = z_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      fs_q    <= '0;
      shamt_q <= '0;
      s_q     <= '0;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_hi_q  <= '0;
      y_lo_q  <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fs_q    <= fs_d;
      shamt_q <= shamt_d;
      s_q     <= s_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_hi_q  <= y_hi_d;
      y_lo_q  <= y_lo_d;
      c_q     <= c_d;
      v_q     <= v_d;
      n_q     <= n_d;
      z_q     <= z_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y_hi = y_hi_q;
  assign y_lo = y_lo_q;
  assign c    = c_q;
  assign v    = v_q;
  assign n    = n_q;
  assign z    = z_q;
  assign dz   = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_w.sv
// ---------------------------------------------------------------
// tb_alu_seq_w : directed self-checking bench for alu_seq_w (W=32)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_alu_seq_w;
  import alu_seq_pkg::*;

  localparam int W   = 32;
  localparam int SHW = 5;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [4:0]     fs;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   s;
  logic [W-1:0]   t;
  logic           busy, done, c, v, n, z, dz;
  logic [W-1:0]   y_hi, y_lo;

  int tests = 0;
  int fails = 0;

  alu_seq_w #(.W(W), .SHW(SHW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .fs      (fs),
    .shamt   (shamt),
    .s       (s),
    .t       (t),
    .busy    (busy),
    .done    (done),
    .y_hi    (y_hi),
    .y_lo    (y_lo),
    .c       (c),
    .v       (v),
    .n       (n),
    .z       (z),
    .dz      (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, optionally poke start again at accept+intr, then check
  // latency, single done pulse, busy window, results and {c,v,n,z,dz}.
  task automatic run_op(input string tag, input logic [4:0] f, input logic [SHW-1:0] sh,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic [4:0] eflags, input int intr);
    int first;
    int ndone;
    logic busy1;
    first = 0;
    ndone = 0;
    busy1 = 1'b0;
    fs = f; shamt = sh; s = a; t = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == 1) busy1 = busy;
      if (done) begin
        ndone++;
        if (first == 0) first = k;
      end
      if (k == intr - 1) begin
        start = 1'b1; fs = FS_ADD; s = 32'h1111_1111; t = 32'h2222_2222;
      end
    end
    chk({tag, ".lat"},   64'(first), 64'(lat));
    chk({tag, ".ndone"}, 64'(ndone), 64'd1);
    chk({tag, ".busy1"}, 64'(busy1), 64'd1);
    chk({tag, ".busyE"}, 64'(busy),  64'd0);
    chk({tag, ".y_hi"},  64'(y_hi),  64'(ehi));
    chk({tag, ".y_lo"},  64'(y_lo),  64'(elo));
    chk({tag, ".cvnzd"}, 64'({c, v, n, z, dz}), 64'(eflags));
  endtask

  initial begin
    int ndone;
    reset_n = 1'b0; start = 1'b0; fs = '0; shamt = '0; s = '0; t = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy_done", 64'({busy, done}), 64'd0);
    chk("rst.y_hi", 64'(y_hi), 64'd0);
    chk("rst.y_lo", 64'(y_lo), 64'd0);
    chk("rst.cvnzd", 64'({c, v, n, z, dz}), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add_ovf", FS_ADD, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, LAT_SINGLE,
           32'h0, 32'h8000_0000, 5'b01100, 0);
    run_op("mul_s", FS_MUL, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, lat_mul(W),
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 5'b00100, 0);
    run_op("mulu", FS_MULU, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, lat_mul(W),
           32'h0000_0004, 32'hFFFF_FFF1, 5'b00000, 0);
    run_op("div_s", FS_DIV, 5'd0, 32'hFFFF_FFF9, 32'h0000_0002, lat_div(W),
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 5'b00100, 0);
    run_op("divu", FS_DIVU, 5'd0, 32'h0000_0064, 32'h0000_0007, lat_div(W),
           32'h0000_0002, 32'h0000_000E, 5'b00000, 0);
    run_op("div_z", FS_DIV, 5'd0, 32'h1234_5678, 32'h0000_0000, lat_div(W),
           32'h1234_5678, 32'hFFFF_FFFF, 5'b00101, 0);
    run_op("div_min", FS_DIV, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, lat_div(W),
           32'h0, 32'h8000_0000, 5'b01100, 0);
    run_op("sra", FS_SRA, 5'd4, 32'h0, 32'h8000_0010, LAT_SINGLE,
           32'h0, 32'hF800_0001, 5'b00100, 0);
    run_op("sll", FS_SLL, 5'd1, 32'h0, 32'h8000_0001, LAT_SINGLE,
           32'h0, 32'h0000_0002, 5'b10000, 0);
    run_op("srl0", FS_SRL, 5'd0, 32'h0, 32'h8000_0001, LAT_SINGLE,
           32'h0, 32'h8000_0001, 5'b00100, 0);
    run_op("sub_neg", FS_SUB, 5'd0, 32'h0, 32'h1, LAT_SINGLE,
           32'h0, 32'hFFFF_FFFF, 5'b00100, 0);
    run_op("sub_eq", FS_SUB, 5'd0, 32'h5, 32'h5, LAT_SINGLE,
           32'h0, 32'h0, 5'b10010, 0);
    run_op("slt", FS_SLT, 5'd0, 32'hFFFF_FFFF, 32'h1, LAT_SINGLE,
           32'h0, 32'h1, 5'b00000, 0);
    run_op("sltu", FS_SLTU, 5'd0, 32'hFFFF_FFFF, 32'h1, LAT_SINGLE,
           32'h0, 32'h0, 5'b00010, 0);
    run_op("nor", FS_NOR, 5'd0, 32'h0F0F_0000, 32'h0000_00FF, LAT_SINGLE,
           32'h0, 32'hF0F0_FF00, 5'b00100, 0);
    run_op("undef", 5'h10, 5'd0, 32'hDEAD_BEEF, 32'h1234_5678, LAT_SINGLE,
           32'h0, 32'h0, 5'b00010, 0);
    run_op("mul_busy", FS_MULU, 5'd0, 32'h3, 32'h7, lat_mul(W),
           32'h0, 32'h0000_0015, 5'b00000, 5);

    // Reset arriving at accept+10 of a divide
    fs = FS_DIV; s = 32'h0000_0064; t = 32'h0000_0007; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid.busy_done", 64'({busy, done}), 64'd0);
    chk("rstmid.y_hi", 64'(y_hi), 64'd0);
    chk("rstmid.y_lo", 64'(y_lo), 64'd0);
    chk("rstmid.cvnzd", 64'({c, v, n, z, dz}), 64'd0);
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("rstmid.nodone", 64'(ndone), 64'd0);

    run_op("post_rst", FS_ADDU, 5'd0, 32'hFFFF_FFFF, 32'h0000_0002, LAT_SINGLE,
           32'h0, 32'h0000_0001, 5'b10000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq_w.md
Name: alu_seq_w

Overview:
Parametrised multi-cycle MIPS-style ALU of width W with registered outputs and a start/busy/done handshake. Single-cycle ops (add/sub/logic/compare/shift) complete in one clock. Signed and unsigned multiply and divide run iteratively, one bit per clock. It drops into the execute stage of the multi-cycle CPU in place of the combinational ALU and feeds the HI/LO and flag registers.

Parameters:
W, 32, operand width; even and ≥8
SHW, $clog2(W), shift-amount width

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous reset, active-low
start  in  1  request; accepted only when busy=0
fs  in  5  function select, sampled on accept
shamt  in  SHW  shift amount, sampled on accept
s  in  W  operand S, sampled on accept
t  in  W  operand T, sampled on accept
busy  out  1  operation in flight
done  out  1  one-cycle pulse: results valid
y_hi  out  W  high result (product high / remainder)
y_lo  out  W  low result
c  out  1  carry / shift-out flag
v  out  1  signed overflow flag
n  out  1  negative flag
z  out  1  zero flag, (y_hi==0)&&(y_lo==0)
dz  out  1  divide-by-zero flag

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; busy, done, y_hi, y_lo, c, v, n, z, dz all 0. Reset mid-operation aborts it; no done pulse is produced.
- FS codes:
  - 00 PASS_S, 01 PASS_T.
  - 02 ADD, 03 ADDU, 04 SUB, 05 SUBU.
  - 06 SLT, 07 SLTU.
  - 08 AND, 09 OR, 0A XOR, 0B NOR.
  - 0C SRL, 0D SRA, 0E SLL (shift t by shamt).
  - 1C MULU, 1D DIVU, 1E MUL (signed), 1F DIV (signed).
  - Any other code: y=0, flags from that zero result, c=v=0.
- Accept: on a clk edge with start=1 and busy=0, latch fs/shamt/s/t. start while busy=1 is ignored; outputs are undisturbed.
- States:
  - IDLE --accept single--> DONE.
  - IDLE --accept 1C/1E--> MUL.
  - IDLE --accept 1D/1F--> DIV.
  - MUL: W iterations --> DONE.
  - DIV: W iterations, then FIX for one cycle (sign correction) --> DONE.
  - DONE --> IDLE.
- Latency from the accept edge to the edge that raises done: single-cycle = 1, MUL/MULU = W+1, DIV/DIVU = W+2.
  - done is high exactly one cycle.
  - busy is high from the cycle after accept through the cycle done is high. A new start is therefore accepted the cycle after done.
- Outputs hold their last values until the next operation completes. They never change while busy.
- Single-cycle ops: y_hi=0, y_lo=result.
  - ADD/SUB: c = carry-out of s+t / s+~t+1; v = signed overflow.
  - ADDU/SUBU: c as above; v=0.
  - SLT/SLTU: y_lo = 0 or 1; c=v=0.
  - Logic ops and PASS: c=v=0.
  - Shifts: c = last bit shifted out, 0 when shamt=0; v=0.
- Multiply:
  - {y_hi,y_lo} = full 2W-bit product, computed shift-add on magnitudes.
  - MUL negates the product when sign(s)≠sign(t).
  - c=v=0; n=y_hi[W-1].
- Divide:
  - Restoring division on magnitudes; y_lo = quotient, y_hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of s.
  - t==0: dz=1, y_lo=all ones, y_hi=s, v=0; still takes the full latency.
  - DIV with s=MIN and t=-1: y_lo=MIN, y_hi=0, v=1.
  - c=0; n=y_lo[W-1].
- dz=0 for all non-divide ops.
- n for non-MUL ops = y_lo[W-1].
- z is always computed on the registered y_hi/y_lo.

Decomposition:
- Package alu_seq_pkg: FS code localparams, state enum (IDLE, MUL, DIV, FIX, DONE), latency constants as functions of W.
- Sub-module iter_muldiv_w (param W): shared 2W-bit shift register, counter, and add/subtract datapath.
  - Inputs: load, mode (mul/div, signed).
  - Outputs: hi, lo, fin.
  - Handles magnitude conversion and the FIX step.
- The top level holds the single-cycle unit, the FSM, and the output/flag registers.

Test Plan (W=32):
1. ADD s=7FFFFFFF, t=00000001 -> done 1 cycle after accept; y_lo=80000000, y_hi=0, v=1, n=1, c=0, z=0.
2. MUL s=00000005, t=FFFFFFFD -> done at accept+33; y_hi=FFFFFFFF, y_lo=FFFFFFF1, n=1. MULU same operands -> y_hi=00000004, y_lo=FFFFFFF1.
3. DIV s=FFFFFFF9 (-7), t=00000002 -> done at accept+34; y_lo=FFFFFFFD, y_hi=FFFFFFFF, dz=0. DIVU s=64, t=7 -> y_lo=0E, y_hi=02.
4. DIV t=0, s=12345678 -> dz=1, y_lo=FFFFFFFF, y_hi=12345678. DIV s=80000000, t=FFFFFFFF -> y_lo=80000000, y_hi=0, v=1.
5. SRA t=80000010, shamt=4 -> y_lo=F8000001, c=0. SLL t=80000001, shamt=1 -> y_lo=00000002, c=1.
6. Handshake and reset:
   - Start MUL, pulse start with ADD at accept+5 -> ignored; the MUL result is unchanged and done fires only once.
   - reset_n=0 at accept+10 of a DIV -> next cycle busy=0, all outputs 0, no done pulse.
